mp64_rst_seq: RTL and testbench

Reset sequencer sitting directly downstream of the reset synchronizer. Its `rst` input is the inverted, synchronized board reset. It holds all subsystem resets asserted for a minimum time, then releases them one stage at a time in fixed order: clocks/PLL glue, then memory, then bus fabric, then CPU core. It also accepts software and watchdog reset requests, re-runs the same sequence for them, and records the cause of the most recent reset for the system-control register block.

---
 rtl/mp64_rst_pkg.sv | 16 +
 rtl/mp64_rst_seq.sv | 106 ++++++++++
 tb/tb_mp64_rst_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mp64_rst_pkg.sv
// Shared types and constants for the reset sequencer.
// The cause bit positions match the layout of the system-control cause register.
package mp64_rst_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam int CAUSE_W   = 3;
   localparam int CAUSE_POR = 0;
   localparam int CAUSE_SW  = 1;
   localparam int CAUSE_WDT = 2;

endpackage

// File: rtl/mp64_rst_seq.sv
// Holds all subsystem resets for HOLD_CYCLES, then releases them in index order, GAP_CYCLES apart.
// Software or watchdog requests restart the sequence. The cause of the last reset is kept until cleared in RUN.
module mp64_rst_seq
   import mp64_rst_pkg::*;
#(
   parameter int NUM_STAGES  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 8,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sw_rst_req,
   input  logic                  wdt_rst_req,
   input  logic                  cause_clr,
   output logic [NUM_STAGES-1:0] rst_stage_out,
   output logic                  seq_done,
   output logic                  busy,
   output logic [CAUSE_W-1:0]    rst_cause
);

   localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [STG_W-1:0] STG_LAST  = STG_W'(NUM_STAGES - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [STG_W-1:0]   stg;
   logic               req;
   logic [CAUSE_W-1:0] req_cause;

   assign req = sw_rst_req | wdt_rst_req;

   always_comb begin
      req_cause            = '0;
      req_cause[CAUSE_SW]  = sw_rst_req;
      req_cause[CAUSE_WDT] = wdt_rst_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= HOLD;
         cnt           <= '0;
         stg           <= '0;
         rst_stage_out <= '1;
         seq_done      <= 1'b0;
         busy          <= 1'b1;
         rst_cause     <= CAUSE_W'(1 << CAUSE_POR);
      end else if (req) begin
         // A request held high parks the sequencer here with cnt pinned at 0.
         state         <= HOLD;
         cnt           <= '0;
         stg           <= '0;
         rst_stage_out <= '1;
         seq_done      <= 1'b0;
         busy          <= 1'b1;
         rst_cause     <= req_cause;
      end else begin
         case (state)
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  rst_stage_out[0] <= 1'b0;
                  cnt              <= '0;
                  if (NUM_STAGES == 1) begin
                     state    <= RUN;
                     seq_done <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     stg   <= STG_W'(1);
                     state <= RELEASE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RELEASE: begin
               if (cnt == GAP_LAST) begin
                  rst_stage_out[stg] <= 1'b0;
                  cnt                <= '0;
                  if (stg == STG_LAST) begin
                     state    <= RUN;
                     seq_done <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     stg <= stg + STG_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (cause_clr) begin
                  rst_cause <= '0;
               end
            end
            default: begin
               state <= HOLD;
               cnt   <= '0;
               stg   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mp64_rst_seq.sv
// Directed bench for the reset sequencer: an edge-count model checked every cycle, plus literal schedule checks.
module tb_mp64_rst_seq;

   localparam int N = 4;
   localparam int H = 16;
   localparam int G = 8;
   localparam int LAST = H + (N - 1) * G;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sw_rst_req = 1'b0;
   logic         wdt_rst_req = 1'b0;
   logic         cause_clr = 1'b0;
   logic [N-1:0] rst_stage_out;
   logic         seq_done;
   logic         busy;
   logic [2:0]   rst_cause;

   int n_chk = 0;
   int n_fail = 0;

   // Model: edges elapsed since the last restart event, and the recorded cause.
   bit       m_valid = 1'b0;
   int       m_since = 0;
   bit [2:0] m_cause = 3'b000;

   mp64_rst_seq #(
      .NUM_STAGES (N),
      .HOLD_CYCLES(H),
      .GAP_CYCLES (G),
      .CNT_W      (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sw_rst_req   (sw_rst_req),
      .wdt_rst_req  (wdt_rst_req),
      .cause_clr    (cause_clr),
      .rst_stage_out(rst_stage_out),
      .seq_done     (seq_done),
      .busy         (busy),
      .rst_cause    (rst_cause)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1'b1;
         m_since = 0;
         m_cause = 3'b001;
      end else if (sw_rst_req || wdt_rst_req) begin
         m_since = 0;
         m_cause = {wdt_rst_req, sw_rst_req, 1'b0};
      end else begin
         if (cause_clr && m_since >= LAST) m_cause = 3'b000;
         if (m_since < 1000000) m_since++;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         logic [N-1:0] exp_out;
         bit           mono_ok;
         for (int k = 0; k < N; k++) exp_out[k] = (m_since < H + k * G);
         chk("model_stage", 32'(rst_stage_out), 32'(exp_out));
         chk("model_done", 32'(seq_done), 32'(m_since >= LAST));
         chk("model_busy", 32'(busy), 32'(m_since < LAST));
         chk("model_cause", 32'(rst_cause), 32'(m_cause));
         mono_ok = 1'b1;
         for (int k = 1; k < N; k++) if (!rst_stage_out[k] && rst_stage_out[k-1]) mono_ok = 1'b0;
         chk("monotonic", 32'(mono_ok), 32'd1);
      end
   end

   // Literal 16/24/32/40 schedule, starting from the negedge just after the restart edge.
   task automatic sched(input string tag, input logic [2:0] cause);
      step(H - 1);
      chk({tag, "_pre16"}, 32'(rst_stage_out), 32'hF);
      step(1);
      chk({tag, "_e16"}, 32'(rst_stage_out), 32'hE);
      step(G);
      chk({tag, "_e24"}, 32'(rst_stage_out), 32'hC);
      step(G);
      chk({tag, "_e32"}, 32'(rst_stage_out), 32'h8);
      step(G - 1);
      chk({tag, "_pre40_done"}, 32'(seq_done), 32'd0);
      step(1);
      chk({tag, "_e40"}, 32'(rst_stage_out), 32'h0);
      chk({tag, "_done"}, 32'(seq_done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_cause"}, 32'(rst_cause), 32'(cause));
   endtask

   initial begin
      // Test 1: power-on reset.
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("por_stage", 32'(rst_stage_out), 32'hF);
         chk("por_cause", 32'(rst_cause), 32'h1);
      end
      rst = 1'b0;
      sched("por", 3'b001);

      // Test 2: single-cycle software request from RUN.
      sw_rst_req = 1'b1;
      step(1);
      sw_rst_req = 1'b0;
      chk("sw_stage", 32'(rst_stage_out), 32'hF);
      chk("sw_done", 32'(seq_done), 32'd0);
      chk("sw_cause", 32'(rst_cause), 32'h2);
      sched("sw", 3'b010);

      // Test 3: watchdog pulse mid-sequence with stages 0 and 1 released.
      sw_rst_req = 1'b1;
      step(1);
      sw_rst_req = 1'b0;
      step(27);
      chk("mid_before", 32'(rst_stage_out), 32'hC);
      wdt_rst_req = 1'b1;
      step(1);
      wdt_rst_req = 1'b0;
      chk("mid_stage", 32'(rst_stage_out), 32'hF);
      chk("mid_cause", 32'(rst_cause), 32'h4);
      sched("wdt", 3'b100);

      // Test 4: both requests held for 10 cycles.
      sw_rst_req  = 1'b1;
      wdt_rst_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("held_stage", 32'(rst_stage_out), 32'hF);
      end
      chk("held_cause", 32'(rst_cause), 32'h6);
      sw_rst_req  = 1'b0;
      wdt_rst_req = 1'b0;
      sched("held", 3'b110);

      // Test 5: cause_clr in RUN, against a request, and during HOLD.
      cause_clr = 1'b1;
      step(1);
      chk("clr_run", 32'(rst_cause), 32'h0);
      sw_rst_req = 1'b1;
      step(1);
      sw_rst_req = 1'b0;
      chk("clr_vs_req", 32'(rst_cause), 32'h2);
      step(3);
      chk("clr_hold", 32'(rst_cause), 32'h2);
      chk("clr_hold_stage", 32'(rst_stage_out), 32'hF);
      cause_clr = 1'b0;
      step(LAST);
      chk("clr_rerun_done", 32'(seq_done), 32'd1);

      // Test 6: rst beats a simultaneous software request mid-sequence.
      sw_rst_req = 1'b1;
      step(1);
      sw_rst_req = 1'b0;
      step(29);
      rst        = 1'b1;
      sw_rst_req = 1'b1;
      step(1);
      rst        = 1'b0;
      sw_rst_req = 1'b0;
      chk("prio_stage", 32'(rst_stage_out), 32'hF);
      chk("prio_cause", 32'(rst_cause), 32'h1);
      sched("prio", 3'b001);

      step(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
